// File: rtl/io_misc_ctrl.sv
// Misc-bus I/O controller: scratch RAM, registered output ports, debounced inputs
// with sticky rising-edge flags, and a one-cycle registered response per command.
module io_misc_ctrl #(
    parameter int DATA_W    = 16,
    parameter int N_IN      = 8,
    parameter int N_OUT     = 4,
    parameter int RAM_DEPTH = 256,
    parameter int DEB_CYC   = 4,
    localparam int OUT_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic [3:0]              op,
    input  logic [DATA_W-1:0]       port,
    input  logic [DATA_W-1:0]       data,
    input  logic [N_IN-1:0]         in_data,
    output logic [DATA_W-1:0]       result,
    output logic                    resp_valid,
    output logic                    write_out,
    output logic [OUT_W-1:0]        out_port,
    output logic [DATA_W-1:0]       out_data,
    output logic [N_OUT*DATA_W-1:0] out_regs
);

    localparam int ADDR_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int IN_IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    typedef enum logic [3:0] {
        OP_RAM_RD  = 4'b0000,
        OP_RAM_WR  = 4'b0001,
        OP_IN_LVL  = 4'b0010,
        OP_OUT_WR  = 4'b0011,
        OP_OUT_RD  = 4'b0100,
        OP_EDGE_RC = 4'b0101
    } op_t;

    logic [DATA_W-1:0] ram     [RAM_DEPTH];
    logic [DATA_W-1:0] out_mem [N_OUT];

    logic [N_IN-1:0]   sync1, sync2, deb, deb_nxt, flags, flags_nxt, rise, clr;
    logic [CNT_W-1:0]  deb_cnt     [N_IN];
    logic [CNT_W-1:0]  deb_cnt_nxt [N_IN];

    logic              accept, in_hit, out_hit, out_wr_hit;
    logic [ADDR_W-1:0] addr;
    logic [IN_IDX_W-1:0] in_idx;
    logic [OUT_W-1:0]  out_idx;
    logic [DATA_W-1:0] rsp_data;

    assign accept     = cs && !rst;
    assign addr       = port[ADDR_W-1:0];
    assign in_idx     = port[IN_IDX_W-1:0];
    assign out_idx    = port[OUT_W-1:0];
    assign in_hit     = port < DATA_W'(N_IN);
    assign out_hit    = port < DATA_W'(N_OUT);
    assign out_wr_hit = accept && (op == OP_OUT_WR) && out_hit;

    // Debounce: counter runs while synced and debounced disagree; any agreement restarts it.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < N_IN; i++) begin
            deb_cnt_nxt[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (deb_cnt[i] == CNT_W'(DEB_CYC - 1)) begin
                    deb_nxt[i] = sync2[i];
                end else begin
                    deb_cnt_nxt[i] = deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A new edge in the same cycle as a read-and-clear survives the clear.
    assign rise      = deb_nxt & ~deb;
    assign clr       = (accept && (op == OP_EDGE_RC)) ? '1 : '0;
    assign flags_nxt = (flags & ~clr) | rise;

    always_comb begin
        rsp_data = '0;
        case (op)
            OP_RAM_RD:  rsp_data = ram[addr];
            OP_IN_LVL:  if (in_hit) rsp_data = {{(DATA_W-1){1'b0}}, deb[in_idx]};
            OP_OUT_RD:  if (out_hit) rsp_data = out_mem[out_idx];
            OP_EDGE_RC: rsp_data = DATA_W'(flags);
            default:    rsp_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && (op == OP_RAM_WR)) begin
            ram[addr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            flags      <= '0;
            result     <= '0;
            resp_valid <= 1'b0;
            write_out  <= 1'b0;
            out_port   <= '0;
            out_data   <= '0;
            for (int i = 0; i < N_IN; i++) deb_cnt[i] <= '0;
            for (int k = 0; k < N_OUT; k++) out_mem[k] <= '0;
        end else begin
            sync1      <= in_data;
            sync2      <= sync1;
            deb        <= deb_nxt;
            flags      <= flags_nxt;
            for (int i = 0; i < N_IN; i++) deb_cnt[i] <= deb_cnt_nxt[i];
            result     <= accept ? rsp_data : '0;
            resp_valid <= accept;
            write_out  <= out_wr_hit;
            if (out_wr_hit) begin
                out_mem[out_idx] <= data;
                out_port         <= out_idx;
                out_data         <= data;
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out_pack
        assign out_regs[k*DATA_W +: DATA_W] = out_mem[k];
    end

endmodule

// File: tb/tb_io_misc_ctrl.sv
// Bench for io_misc_ctrl: command responses checked through an expected-result queue,
// side effects (ports, reset) checked inline by each scenario task.
module tb_io_misc_ctrl;

    localparam int DATA_W    = 16;
    localparam int N_IN      = 8;
    localparam int N_OUT     = 4;
    localparam int RAM_DEPTH = 256;
    localparam int DEB_CYC   = 4;

    localparam logic [3:0] RAM_RD  = 4'b0000;
    localparam logic [3:0] RAM_WR  = 4'b0001;
    localparam logic [3:0] IN_LVL  = 4'b0010;
    localparam logic [3:0] OUT_WR  = 4'b0011;
    localparam logic [3:0] OUT_RD  = 4'b0100;
    localparam logic [3:0] EDGE_RC = 4'b0101;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cs;
    logic [3:0]              op;
    logic [DATA_W-1:0]       port;
    logic [DATA_W-1:0]       data;
    logic [N_IN-1:0]         in_data;
    logic [DATA_W-1:0]       result;
    logic                    resp_valid;
    logic                    write_out;
    logic [1:0]              out_port;
    logic [DATA_W-1:0]       out_data;
    logic [N_OUT*DATA_W-1:0] out_regs;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    io_misc_ctrl #(
        .DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT),
        .RAM_DEPTH(RAM_DEPTH), .DEB_CYC(DEB_CYC)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .op(op), .port(port), .data(data),
        .in_data(in_data), .result(result), .resp_valid(resp_valid),
        .write_out(write_out), .out_port(out_port), .out_data(out_data),
        .out_regs(out_regs)
    );

    always #5 clk = ~clk;

    // Response scoreboard: every accepted command must produce exactly one response next cycle.
    always @(posedge clk) begin
        logic pend;
        logic [DATA_W-1:0] e;
        pend = (cs === 1'b1) && (rst === 1'b0);
        #1;
        n_checks++;
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_scoreboard: response due but expected queue empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (resp_valid !== 1'b1 || result !== e) begin
                    n_fail++;
                    $display("FAIL resp: got resp_valid=%b result=%h, want resp_valid=1 result=%h at %0t",
                             resp_valid, result, e, $time);
                end
            end
        end else if (resp_valid !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL idle_resp: got resp_valid=%b result=%h, want 0/0000 at %0t",
                     resp_valid, result, $time);
        end
    end

    task automatic issue(input logic [3:0] o, input logic [DATA_W-1:0] p,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e);
        @(negedge clk);
        cs = 1'b1; op = o; port = p; data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cs = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cs = 1'b0;
        idle(3);
        n_checks++;
        if (result !== '0 || resp_valid !== 1'b0 || write_out !== 1'b0 ||
            out_port !== '0 || out_data !== '0 || out_regs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h rv=%b wo=%b op=%h od=%h regs=%h, want all 0",
                     result, resp_valid, write_out, out_port, out_data, out_regs);
        end
        rst = 1'b0;
    endtask

    task automatic test_ram;
        issue(RAM_WR, 16'h0012, 16'hBEEF, 16'h0000);
        issue(RAM_RD, 16'h0012, 16'h0000, 16'hBEEF);
        issue(RAM_RD, 16'h0112, 16'h0000, 16'hBEEF);
        issue(RAM_WR, 16'h0034, 16'h1234, 16'h0000);
        issue(RAM_RD, 16'h0034, 16'h0000, 16'h1234);
        issue(RAM_RD, 16'h0012, 16'h0000, 16'hBEEF);
        idle(2);
    endtask

    task automatic test_out_wr;
        issue(OUT_WR, 16'd2, 16'h00A5, 16'h0000);
        @(posedge clk); #1;
        n_checks++;
        if (write_out !== 1'b1 || out_port !== 2'd2 || out_data !== 16'h00A5 ||
            out_regs !== 64'h0000_00A5_0000_0000) begin
            n_fail++;
            $display("FAIL out_wr_legal: wo=%b port=%0d data=%h regs=%h, want 1/2/00a5/0000_00a5_0000_0000",
                     write_out, out_port, out_data, out_regs);
        end
        issue(OUT_WR, 16'd7, 16'h1111, 16'h0000);
        @(posedge clk); #1;
        n_checks++;
        if (write_out !== 1'b0 || out_regs !== 64'h0000_00A5_0000_0000) begin
            n_fail++;
            $display("FAIL out_wr_oob: wo=%b regs=%h, want 0/0000_00a5_0000_0000", write_out, out_regs);
        end
        issue(OUT_RD, 16'd2, 16'h0000, 16'h00A5);
        issue(OUT_RD, 16'd9, 16'h0000, 16'h0000);
        issue(OUT_RD, 16'd0, 16'h0000, 16'h0000);
        idle(2);
    endtask

    task automatic test_in_lvl;
        @(negedge clk); cs = 1'b0; in_data[3] = 1'b1;
        idle(4);
        issue(IN_LVL, 16'd3, 16'h0000, 16'h0000);
        issue(IN_LVL, 16'd3, 16'h0000, 16'h0001);
        issue(IN_LVL, 16'd6, 16'h0000, 16'h0000);
        idle(1);
    endtask

    task automatic test_edge_rc;
        issue(EDGE_RC, 16'd0, 16'h0000, 16'h0008);
        issue(EDGE_RC, 16'd0, 16'h0000, 16'h0000);
        @(negedge clk); cs = 1'b0; in_data[3] = 1'b0;
        idle(9);
        issue(EDGE_RC, 16'd0, 16'h0000, 16'h0000);
        issue(IN_LVL, 16'd3, 16'h0000, 16'h0000);
        idle(1);
    endtask

    task automatic test_glitch;
        @(negedge clk); cs = 1'b0; in_data[3] = 1'b1;
        idle(2);
        @(negedge clk); in_data[3] = 1'b0;
        idle(10);
        issue(IN_LVL, 16'd3, 16'h0000, 16'h0000);
        issue(EDGE_RC, 16'd0, 16'h0000, 16'h0000);
        idle(1);
    endtask

    task automatic test_edge_same_cycle;
        @(negedge clk); cs = 1'b0; in_data[3] = 1'b1;
        idle(4);
        issue(EDGE_RC, 16'd0, 16'h0000, 16'h0000);
        issue(EDGE_RC, 16'd0, 16'h0000, 16'h0008);
        idle(1);
    endtask

    task automatic test_reset_in_flight;
        @(negedge clk); cs = 1'b0; in_data = '0;
        @(negedge clk);
        cs = 1'b1; op = OUT_WR; port = 16'd1; data = 16'h5A5A; rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b0 || write_out !== 1'b0 || out_regs !== '0) begin
            n_fail++;
            $display("FAIL reset_in_flight: rv=%b wo=%b regs=%h, want 0/0/0", resp_valid, write_out, out_regs);
        end
        @(negedge clk); rst = 1'b0; cs = 1'b0;
        issue(RAM_RD, 16'h0012, 16'h0000, 16'hBEEF);
        issue(RAM_RD, 16'h0034, 16'h0000, 16'h1234);
        idle(2);
    endtask

    task automatic test_illegal;
        issue(4'b1111, 16'd2, 16'hFFFF, 16'h0000);
        issue(IN_LVL, 16'd20, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        n_checks++;
        if (write_out !== 1'b0 || out_regs !== '0) begin
            n_fail++;
            $display("FAIL illegal_no_effect: wo=%b regs=%h, want 0/0", write_out, out_regs);
        end
        issue(OUT_RD, 16'd2, 16'h0000, 16'h0000);
        issue(RAM_RD, 16'h0012, 16'h0000, 16'hBEEF);
        idle(2);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; op = '0; port = '0; data = '0; in_data = '0;
        test_reset;
        test_ram;
        test_out_wr;
        test_in_lvl;
        test_edge_rc;
        test_glitch;
        test_edge_same_cycle;
        test_reset_in_flight;
        test_illegal;
        idle(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
